// File: rtl/pll_ctrl_pkg.sv
// Shared types and defaults for the PLL lock controller.
// Holds the FSM state enum, the state width and the default cycle parameters.
package pll_ctrl_pkg;

    localparam int STATE_W = 3;

    localparam int DEF_RST_PULSE_CYC    = 16;
    localparam int DEF_LOCK_STABLE_CYC  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYC = 50000;
    localparam int DEF_MAX_RETRY        = 3;

    typedef enum logic [STATE_W-1:0] {
        S_PLLRST = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAIL   = 3'd4
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for an asynchronous level input.
// Ports: i_clk (clock), i_rst (async active-high reset), i_d (async in), o_q (synced out).
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock,
// then releases the downstream reset; re-sequences on loss of lock or timeout.
// Ports: refclk, rst (async active-high), pll_locked (async) in;
//        pll_rst, sys_rst, ready, lock_lost, state[2:0], fail out (all registered).
// Optional macro PLL_LOCK_RETRY_EN: bounded retries ending in S_FAIL.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int MAX_RETRY        = DEF_MAX_RETRY
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic               lock_lost,
    output logic [STATE_W-1:0] state,
    output logic               fail
);

    localparam int CNT_MAX = max3(RST_PULSE_CYC, LOCK_STABLE_CYC,
                                  LOCK_TIMEOUT_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYC - 1);

    logic w_lk;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_timeout;
    logic             w_lost_nxt;

    logic r_pll_rst;
    logic r_sys_rst;
    logic r_ready;
    logic r_lock_lost;
    logic r_fail;

    sync_2ff u_sync (
        .i_clk (refclk),
        .i_rst (rst),
        .i_d   (pll_locked),
        .o_q   (w_lk)
    );

    // Saturating increment: the counter parks at all-ones instead of wrapping.
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

`ifdef PLL_LOCK_RETRY_EN
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

    logic [RETRY_W-1:0] r_retry;
    logic [RETRY_W-1:0] w_retry_nxt;
`else
    logic w_unused_retry;
    assign w_unused_retry = (MAX_RETRY != 0);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_timeout   = 1'b0;
        w_lost_nxt  = 1'b0;
        unique case (r_state)
            S_PLLRST: begin
                if (r_cnt >= RST_LAST) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_WAIT: begin
                // Lock is tested first so it wins over a same-cycle timeout.
                if (w_lk) begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_PLLRST;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_STABLE: begin
                if (!w_lk) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= STB_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_RUN: begin
                w_cnt_nxt = '0;
                if (!w_lk) begin
                    w_state_nxt = S_PLLRST;
                    w_lost_nxt  = 1'b1;
                end
            end
            S_FAIL: begin
                w_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt = S_PLLRST;
                w_cnt_nxt   = '0;
            end
        endcase

`ifdef PLL_LOCK_RETRY_EN
        w_retry_nxt = r_retry;
        if (w_timeout) begin
            if (r_retry >= RETRY_LAST) begin
                w_state_nxt = S_FAIL;
            end
            w_retry_nxt = (r_retry == '1) ? r_retry : r_retry + 1'b1;
        end
        if (w_state_nxt == S_RUN) begin
            w_retry_nxt = '0;
        end
`endif
    end

    // Outputs are decoded from the next state so they flip on the same
    // edge as the state register.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state     <= S_PLLRST;
            r_cnt       <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pll_rst   <= (w_state_nxt == S_PLLRST);
            r_sys_rst   <= (w_state_nxt != S_RUN);
            r_ready     <= (w_state_nxt == S_RUN);
            r_lock_lost <= w_lost_nxt;
`ifdef PLL_LOCK_RETRY_EN
            r_fail      <= (w_state_nxt == S_FAIL);
`else
            r_fail      <= 1'b0;
`endif
        end
    end

`ifdef PLL_LOCK_RETRY_EN
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_retry <= '0;
        end else begin
            r_retry <= w_retry_nxt;
        end
    end
`endif

    assign pll_rst   = r_pll_rst;
    assign sys_rst   = r_sys_rst;
    assign ready     = r_ready;
    assign lock_lost = r_lock_lost;
    assign state     = r_state;
    assign fail      = r_fail;

endmodule

// File: doc/pll_lock_ctrl.md
PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 SHALL have parameter RST_PULSE_CYC, default 16, PLL reset pulse length in refclk cycles.
REQ-002 SHALL have parameter LOCK_STABLE_CYC, default 1024, consecutive locked cycles required before release.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYC, default 50000, max cycles to wait for lock (1 ms at 50 MHz).
REQ-004 SHALL have parameter MAX_RETRY, default 3, PLL reset attempts before failure (used only with REQ-027 macro).
REQ-005 SHALL have one clock and an asynchronous, active-high reset, with ports: refclk  in  1  sole clock (50 MHz board reference).
REQ-006 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port: pll_locked  in  1  PLL lock flag, asynchronous to refclk.
REQ-008 SHALL have port: pll_rst  out  1  drives PLL rst input, active-high.
REQ-009 SHALL have port: sys_rst  out  1  reset to pixel/downstream logic, active-high.
REQ-010 SHALL have port: ready  out  1  clocks locked and stable.
REQ-011 SHALL have port: lock_lost  out  1  one-cycle pulse on loss of lock while running.
REQ-012 SHALL have port: state  out  3  current FSM state encoding.
REQ-013 SHALL have port: fail  out  1  retries exhausted (always 0 without REQ-027 macro).

Function
REQ-014 SHALL synchronize pll_locked through two flops to lk; all decisions use lk (2-cycle input latency).
REQ-015 SHALL implement states S_PLLRST=0, S_WAIT=1, S_STABLE=2, S_RUN=3, S_FAIL=4; all outputs registered.
REQ-016 In S_PLLRST: pll_rst=1 for exactly RST_PULSE_CYC cycles, then -> S_WAIT with cycle counter cleared.
REQ-017 In S_WAIT: pll_rst=0; lk=1 -> S_STABLE; counter reaching LOCK_TIMEOUT_CYC-1 with lk=0 -> timeout (REQ-021).
REQ-018 In S_STABLE: lk held 1 for LOCK_STABLE_CYC consecutive cycles -> S_RUN; any lk=0 -> S_WAIT with timeout counter restarted at 0.
REQ-019 In S_RUN: sys_rst=0, ready=1; lk=0 -> lock_lost=1 for one cycle, sys_rst=1, ready=0 next cycle, -> S_PLLRST.
REQ-020 sys_rst SHALL be 1 and ready 0 in every state except S_RUN; both change on the same edge.
REQ-021 Timeout without macro: -> S_PLLRST, unlimited retries.
REQ-022 Counter SHALL be sized for the largest of the three cycle parameters and SHALL saturate, never wrap.
REQ-023 lk=1 and timeout in same cycle: lock wins (-> S_STABLE).

Reset
REQ-024 rst=1 SHALL asynchronously force S_PLLRST, pll_rst=1, sys_rst=1, ready=0, lock_lost=0, fail=0, counters and sync flops 0.
REQ-025 After rst deasserts, full RST_PULSE_CYC pulse SHALL be issued before S_WAIT.
REQ-026 rst mid-operation (any state, including S_FAIL) SHALL restart the sequence from REQ-024.

Configuration
REQ-027 With PLL_LOCK_RETRY_EN defined: each timeout increments retry_cnt; retry_cnt reaching MAX_RETRY -> S_FAIL (pll_rst=0, sys_rst=1, ready=0, fail=1) until rst; retry_cnt clears on entering S_RUN.
REQ-028 Without PLL_LOCK_RETRY_EN: no retry counter, S_FAIL unreachable, fail tied 0.

Structure
REQ-029 Package pll_ctrl_pkg SHALL hold state enum typedef, STATE_W=3, and default parameter constants.
REQ-030 Sub-module sync_2ff (single-bit two-flop synchronizer) SHALL implement REQ-014.

Verification (RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32, MAX_RETRY=2)
REQ-031 Release rst, raise pll_locked at cycle 10 -> pll_rst high cycles 0-3, ready=1/sys_rst=0 at cycle 10+2+8 (+/-1 per registration).
REQ-032 In S_STABLE drop pll_locked for 1 cycle at stable count 5 -> returns S_WAIT, ready only after fresh 8 stable cycles.
REQ-033 In S_RUN drop pll_locked -> lock_lost single pulse 3 cycles later, sys_rst=1, pll_rst 4-cycle pulse, relock reaches S_RUN.
REQ-034 Never lock, macro off -> pll_rst pulse every 4+32 cycles indefinitely, fail=0.
REQ-035 Never lock, macro on -> two timeouts then state=4, fail=1, pll_rst=0; assert rst -> state=0, fail=0.
REQ-036 Assert rst in S_RUN mid-cycle -> outputs take REQ-024 values immediately, before next refclk edge.
